ripply_carry_adder: RTL and testbench

RIPPLY_CARRY_ADDER -- requirements
Module: ripply_carry_adder

---
 rtl/ripply_carry_adder_pkg.sv | 10 +
 rtl/full_adder.sv | 16 +
 rtl/ripply_carry_adder.sv | 55 +++++
 tb/tb_ripply_carry_adder.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/ripply_carry_adder_pkg.sv
// Shared helpers for the ripple-carry adder.
// Overflow derivation from the top two carries lives here so all adders agree.
package ripply_carry_adder_pkg;

    // Signed overflow: the carry into the MSB differs from the carry out of it.
    function automatic logic ovf_flag(input logic c_out, input logic c_msb);
        return c_out ^ c_msb;
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell; the adder chains these LSB to MSB.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);

endmodule

// File: rtl/ripply_carry_adder.sv
// Parameterized ripple-carry adder with combinational sum/carry/overflow
// and a registered copy of sum/carry behind an async active-low reset.
module ripply_carry_adder
    import ripply_carry_adder_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             cin,
    output logic [width-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [width-1:0] sum_q,
    output logic             cout_q
);

    // c[i] is the carry into bit i; c[width] is the carry out.
    logic [width:0]   c;
    logic [width-1:0] sum_d;
    logic             cout_d;

    assign c[0] = cin;

    genvar i;
    generate
        for (i = 0; i < width; i++) begin : g_bit
            full_adder u_fa (
                .a  (a[i]),
                .b  (b[i]),
                .ci (c[i]),
                .s  (sum[i]),
                .co (c[i+1])
            );
        end
    endgenerate

    assign cout   = c[width];
    assign ovf    = ovf_flag(c[width], c[width-1]);
    assign sum_d  = sum;
    assign cout_d = cout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

endmodule

// File: tb/tb_ripply_carry_adder.sv
// Self-checking bench: exhaustive 8-bit sweep, corners, registered path,
// reset behaviour and random vectors at widths 1 and 16 against arithmetic.
module tb_ripply_carry_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [7:0]  a8, b8, sum8, sum_q8;
    logic        cin8, cout8, ovf8, cout_q8;
    logic [0:0]  a1, b1, sum1, sum_q1;
    logic        cin1, cout1, ovf1, cout_q1;
    logic [15:0] a16, b16, sum16, sum_q16;
    logic        cin16, cout16, ovf16, cout_q16;

    ripply_carry_adder #(.width(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .ovf(ovf8), .sum_q(sum_q8), .cout_q(cout_q8)
    );
    ripply_carry_adder #(.width(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .cin(cin1),
        .sum(sum1), .cout(cout1), .ovf(ovf1), .sum_q(sum_q1), .cout_q(cout_q1)
    );
    ripply_carry_adder #(.width(16)) u_dut16 (
        .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .cin(cin16),
        .sum(sum16), .cout(cout16), .ovf(ovf16), .sum_q(sum_q16), .cout_q(cout_q16)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Overflow reference: signed interpretation of the operands, result out of range.
    function automatic logic ref_ovf(input int w, input longint unsigned av,
                                     input longint unsigned bv, input logic ci);
        longint sa, sb, tot, lim;
        lim = longint'(1) << (w - 1);
        sa  = (av >= longint'(lim)) ? longint'(av) - (lim << 1) : longint'(av);
        sb  = (bv >= longint'(lim)) ? longint'(bv) - (lim << 1) : longint'(bv);
        tot = sa + sb + longint'(ci);
        return (tot > lim - 1) || (tot < -lim);
    endfunction

    task automatic set8(input int av, input int bv, input logic ci);
        a8 = av[7:0]; b8 = bv[7:0]; cin8 = ci;
    endtask

    initial begin
        logic [8:0]  exp_q;
        logic [16:0] exp16;
        int          ra, rb;
        logic        rc;

        set8(0, 0, 1'b0);
        a1 = '0; b1 = '0; cin1 = 1'b0;
        a16 = '0; b16 = '0; cin16 = 1'b0;

        // Reset state and combinational validity during reset
        #2;
        chk("rst_sum_q", sum_q8, 0);
        chk("rst_cout_q", cout_q8, 0);
        set8(100, 50, 1'b1);
        #1;
        chk("rst_comb_sum", {cout8, sum8}, 151);
        @(posedge clk); #1;
        chk("rst_hold_sum_q", sum_q8, 0);

        // Corners and overflow cases
        set8(255, 1, 1'b0);   #1; chk("c_ff_1", {cout8, sum8}, 9'h100);
        set8(255, 255, 1'b1); #1; chk("c_ff_ff_1", {cout8, sum8}, 9'h1ff);
        set8(0, 0, 1'b1);     #1; chk("c_0_0_1", {cout8, sum8}, 9'h001);
        set8(127, 1, 1'b0);   #1; chk("o_7f_1", {ovf8, cout8, sum8}, {1'b1, 9'h080});
        set8(128, 128, 1'b0); #1; chk("o_80_80", {ovf8, cout8, sum8}, {1'b1, 9'h100});
        set8(255, 0, 1'b1);   #1; chk("c_ff_0_1", {cout8, sum8}, 9'h100);

        // Release reset, then registered path with 3+4
        @(negedge clk);
        rst_n = 1'b1;
        set8(3, 4, 1'b0);
        #1;
        chk("reg_before_edge", {cout_q8, sum_q8}, 0);
        @(posedge clk); #1;
        chk("reg_sum_q", sum_q8, 7);
        chk("reg_cout_q", cout_q8, 0);

        // Mid-operation reset between edges
        @(negedge clk);
        set8(200, 100, 1'b1);
        @(posedge clk); #1;
        chk("pre_rst_q", {cout_q8, sum_q8}, 301);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum_q", sum_q8, 0);
        chk("mid_rst_cout_q", cout_q8, 0);
        chk("mid_rst_comb", {cout8, sum8}, 301);
        set8(10, 20, 1'b0);
        #1;
        chk("mid_rst_follow", {cout8, sum8}, 30);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("release_capture", {cout_q8, sum_q8}, 30);

        // Exhaustive 8-bit sweep, cin=0
        for (int ia = 0; ia < 256; ia++) begin
            for (int ib = 0; ib < 256; ib++) begin
                set8(ia, ib, 1'b0);
                #1;
                chk("sweep_sum", {cout8, sum8}, 64'(ia + ib));
                chk("sweep_ovf", ovf8, ref_ovf(8, ia, ib, 1'b0));
            end
        end

        // Random registered stream at width 8
        @(negedge clk);
        exp_q = '0;
        for (int k = 0; k < 200; k++) begin
            ra = int'($urandom_range(255)); rb = int'($urandom_range(255));
            rc = 1'($urandom_range(1));
            set8(ra, rb, rc);
            exp_q = 9'(ra + rb + int'(rc));
            @(negedge clk);
            chk("rnd_reg8", {cout_q8, sum_q8}, exp_q);
        end

        // Random vectors at widths 1 and 16
        for (int k = 0; k < 300; k++) begin
            a1 = 1'($urandom_range(1)); b1 = 1'($urandom_range(1));
            cin1 = 1'($urandom_range(1));
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom_range(1));
            #1;
            chk("w1_sum", {cout1, sum1}, 64'(int'(a1) + int'(b1) + int'(cin1)));
            chk("w1_ovf", ovf1, ref_ovf(1, a1, b1, cin1));
            exp16 = 17'(int'(a16) + int'(b16) + int'(cin16));
            chk("w16_sum", {cout16, sum16}, exp16);
            chk("w16_ovf", ovf16, ref_ovf(16, a16, b16, cin16));
        end

        // Registered path at the other widths
        @(negedge clk);
        a16 = 16'hffff; b16 = 16'h0001; cin16 = 1'b1;
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        @(negedge clk);
        chk("w16_reg", {cout_q16, sum_q16}, 17'h10001);
        chk("w1_reg", {cout_q1, sum_q1}, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
